// File: rtl/video_src_sched_if.sv
// Stream bundle between the pattern-generator bank, the scheduler and the sink.
interface video_src_sched_if #(
    parameter int N    = 4,
    parameter int BITS = 8
);
    logic [N*BITS-1:0] in_data;
    logic [N-1:0]      in_sop;
    logic [N-1:0]      in_eop;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [BITS-1:0]   out_data;
    logic              out_sop;
    logic              out_eop;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_sop, in_eop, in_valid, out_ready,
        output in_ready, out_data, out_sop, out_eop, out_valid
    );

    modport master (
        output in_data, in_sop, in_eop, in_valid, out_ready,
        input  in_ready, out_data, out_sop, out_eop, out_valid
    );
endinterface

// File: rtl/video_src_sched.sv
// Frame-aligned scheduler: grants one of N sources to the sink, switching only on eop.
//   state | meaning
//   IDLE  | nothing granted, waiting for enable
//   SEEK  | discarding cur's beats until its sop is presented
//   PASS  | cur forwarded combinationally to the sink
module video_src_sched #(
    parameter int N      = 4,
    parameter int BITS   = 8,
    parameter int FRAMES = 1
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               enable,
    input  logic               auto,
    input  logic [2:0]         sel_in,
    video_src_sched_if.slave   vif,
    output logic [2:0]         cur_sel,
    output logic               frame_done
);
    typedef enum logic [1:0] {IDLE, SEEK, PASS} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cur_q, cur_d, cur_inc;
    logic [7:0]        cnt_q, cnt_d;
    logic              sel_ok, eop_xfer;
    logic              s_valid, s_sop, s_eop, s_rdy;
    logic [BITS-1:0]   s_data;
    logic [N-1:0]      rdy_vec;
    logic [BITS-1:0]   o_data;
    logic              o_sop, o_eop, o_valid;

    // Select the granted source's lanes.
    always_comb begin
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
        s_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (cur_q == 3'(i)) begin
                s_valid = vif.in_valid[i];
                s_sop   = vif.in_sop[i];
                s_eop   = vif.in_eop[i];
                s_data  = vif.in_data[i*BITS +: BITS];
            end
        end
    end

    assign sel_ok  = ({1'b0, sel_in} < 4'(N));
    assign cur_inc = (cur_q == 3'(N-1)) ? 3'd0 : cur_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        eop_xfer = 1'b0;
        s_rdy    = 1'b0;
        o_data   = '0;
        o_sop    = 1'b0;
        o_eop    = 1'b0;
        o_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    cur_d   = (!auto && sel_ok) ? sel_in : cur_q;
                    cnt_d   = 8'd0;
                    state_d = SEEK;
                end
            end
            SEEK: begin
                // Hold the sop beat so it is forwarded once PASS is entered.
                s_rdy = !(s_valid && s_sop);
                if (s_valid && s_sop) state_d = PASS;
            end
            PASS: begin
                o_data  = s_data;
                o_sop   = s_sop;
                o_eop   = s_eop;
                o_valid = s_valid;
                s_rdy   = vif.out_ready;
                if (s_valid && vif.out_ready && s_eop) begin
                    eop_xfer = 1'b1;
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (auto) begin
                        if (cnt_q == 8'(FRAMES-1)) begin
                            cur_d   = cur_inc;
                            cnt_d   = 8'd0;
                            state_d = SEEK;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else if (sel_ok && sel_in != cur_q) begin
                        cur_d   = sel_in;
                        cnt_d   = 8'd0;
                        state_d = SEEK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N; i++) rdy_vec[i] = s_rdy && (cur_q == 3'(i));
    end

    assign vif.in_ready  = rdy_vec;
    assign vif.out_data  = o_data;
    assign vif.out_sop   = o_sop;
    assign vif.out_eop   = o_eop;
    assign vif.out_valid = o_valid;
    assign cur_sel       = cur_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= IDLE;
            cur_q      <= 3'd0;
            cnt_q      <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            frame_done <= eop_xfer;
        end
    end
endmodule

// File: tb/tb_video_src_sched.sv
// Bench for video_src_sched: behavioural sources plus a frame-level scheduler model.
module tb_video_src_sched;
    localparam int N      = 4;
    localparam int BITS   = 8;
    localparam int FRAMES = 2;
    localparam int FLEN   = 8;
    localparam int M_OFF  = 0;
    localparam int M_HUNT = 1;
    localparam int M_FWD  = 2;

    logic       clk = 1'b0;
    logic       srst, enable, auto;
    logic [2:0] sel_in, cur_sel;
    logic       frame_done;

    video_src_sched_if #(.N(N), .BITS(BITS)) vif ();

    video_src_sched #(.N(N), .BITS(BITS), .FRAMES(FRAMES)) dut (
        .clk(clk), .srst(srst), .enable(enable), .auto(auto), .sel_in(sel_in),
        .vif(vif.slave), .cur_sel(cur_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int pos [N];
    int par [N];
    bit hold[N];
    int total = 0;
    int bad   = 0;
    int ph, g, shown;
    bit fd;
    int sop_log[$];

    function automatic logic [BITS-1:0] pix(int i);
        return BITS'(((i + 1) << 4) | (par[i] << 3) | pos[i]);
    endfunction

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            vif.in_data[i*BITS +: BITS] = pix(i);
            vif.in_sop[i]   = (pos[i] == 0);
            vif.in_eop[i]   = (pos[i] == FLEN - 1);
            vif.in_valid[i] = !hold[i];
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance sources and model.
    task automatic cycle();
        logic [N-1:0]    er;
        logic [BITS-1:0] edat;
        bit v, s, e, ev, es, ee, ordy, sel_legal;
        bit xfer[N];
        @(negedge clk);
        v = !hold[g]; s = (pos[g] == 0); e = (pos[g] == FLEN - 1);
        ordy = vif.out_ready;
        er = '0; ev = 0; es = 0; ee = 0; edat = '0;
        if (ph == M_HUNT) er[g] = !(v && s);
        else if (ph == M_FWD) begin
            er[g] = ordy; ev = v; es = s; ee = e; edat = pix(g);
        end
        chk("in_ready",   32'(vif.in_ready),  32'(er));
        chk("out_valid",  32'(vif.out_valid), 32'(ev));
        chk("out_sop",    32'(vif.out_sop),   32'(es));
        chk("out_eop",    32'(vif.out_eop),   32'(ee));
        chk("out_data",   32'(vif.out_data),  32'(edat));
        chk("cur_sel",    32'(cur_sel),       32'(g));
        chk("frame_done", 32'(frame_done),    32'(fd));
        if (ph == M_FWD && v && s && ordy) sop_log.push_back(g);
        for (int i = 0; i < N; i++) xfer[i] = vif.in_valid[i] && vif.in_ready[i];
        @(posedge clk);
        #1;
        sel_legal = (int'(sel_in) < N);
        fd = 0;
        if (srst) begin
            ph = M_OFF; g = 0; shown = 0;
        end else if (ph == M_OFF) begin
            if (enable) begin
                if (!auto && sel_legal) g = int'(sel_in);
                shown = 0; ph = M_HUNT;
            end
        end else if (ph == M_HUNT) begin
            if (v && s) ph = M_FWD;
        end else if (v && e && ordy) begin
            fd = 1;
            if (!enable) ph = M_OFF;
            else if (auto) begin
                shown++;
                if (shown == FRAMES) begin
                    g = (g + 1) % N; shown = 0; ph = M_HUNT;
                end
            end else if (sel_legal && int'(sel_in) != g) begin
                g = int'(sel_in); shown = 0; ph = M_HUNT;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) begin
                pos[i]++;
                if (pos[i] == FLEN) begin pos[i] = 0; par[i] ^= 1; end
            end
        end
        drive_src();
    endtask

    initial begin
        bit found;
        srst = 1; enable = 0; auto = 0; sel_in = 3'd0; vif.out_ready = 1;
        for (int i = 0; i < N; i++) begin pos[i] = 0; par[i] = 0; hold[i] = 0; end
        ph = M_OFF; g = 0; shown = 0; fd = 0;
        drive_src();
        @(posedge clk); #1;

        // Reset held with everything valid, then one idle cycle after release.
        repeat (2) cycle();
        srst = 0;
        cycle();
        chk("reset_ready", 32'(vif.in_ready), 32'd0);

        // Auto rotation: two frames per source, sop order 0,0,1,1,2,2,3,3,0.
        enable = 1; auto = 1;
        sop_log.delete();
        repeat (90) cycle();
        chk("rot_count_ok", 32'(sop_log.size() >= 9), 32'd1);
        for (int k = 0; k < 9 && k < sop_log.size(); k++)
            chk("rot_order", 32'(sop_log[k]), 32'((k / 2) % N));

        // Manual select changed mid-frame at pixel 3 of source 0.
        auto = 0; sel_in = 3'd0;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            cycle();
            if (ph == M_FWD && g == 0 && pos[0] == 3) found = 1;
        end
        chk("wait_src0_px3", 32'(found), 32'd1);
        sel_in = 3'd2;
        repeat (20) cycle();
        chk("manual_cur", 32'(cur_sel), 32'd2);
        chk("manual_sop", 32'(sop_log[$]), 32'd2);
        sel_in = 3'd5;
        repeat (30) cycle();
        chk("illegal_sel", 32'(cur_sel), 32'd2);

        // Random backpressure during auto rotation.
        auto = 1;
        repeat (300) begin
            vif.out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        vif.out_ready = 1;

        // Unaligned seek: source 1 parked at pixel 5 before being selected.
        auto = 0; sel_in = 3'd0;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            cycle();
            if (ph == M_FWD && g == 0) found = 1;
        end
        chk("wait_src0", 32'(found), 32'd1);
        pos[1] = 5;
        drive_src();
        sel_in = 3'd1;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            cycle();
            if (ph == M_FWD && g == 1) found = 1;
        end
        chk("wait_src1", 32'(found), 32'd1);
        repeat (2) cycle();
        chk("unaligned_sop", 32'(sop_log[$]), 32'd1);

        // Enable dropped at pixel 2: frame completes, then idle.
        auto = 1;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            cycle();
            if (ph == M_FWD && pos[g] == 2) found = 1;
        end
        chk("wait_px2", 32'(found), 32'd1);
        enable = 0;
        repeat (20) cycle();
        chk("drop_idle", 32'(vif.in_ready), 32'd0);

        // Reset at pixel 4 of a frame.
        enable = 1;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            cycle();
            if (ph == M_FWD && g != 0 && pos[g] == 4) found = 1;
        end
        chk("wait_px4", 32'(found), 32'd1);
        srst = 1;
        cycle();
        srst = 0;
        chk("srst_cur", 32'(cur_sel), 32'd0);
        chk("srst_valid", 32'(vif.out_valid), 32'd0);
        repeat (30) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
